// File: rtl/matriz_scan_controller_if.sv
// Scan controller bus: run/image controls in, row/image selects and strobes out.
//   enable          - run the scan when 1, idle when 0
//   auto_alternate  - 1: image toggles every FRAMES_PER_IMAGE frames; 0: manual image
//   manual_img      - image requested while auto_alternate = 0
//   Seletor_Linhas  - current row index
//   Seletor_imagem  - current image index
//   linha_ativa     - row drive enable (low while blanked or idle)
//   frame_start     - one-cycle pulse at the start of row 0
//   tick_linha      - one-cycle pulse at the start of every row slot
// master drives the controls (system side); slave is the scan controller.
interface matriz_scan_controller_if;
   logic       enable;
   logic       auto_alternate;
   logic       manual_img;
   logic [2:0] Seletor_Linhas;
   logic       Seletor_imagem;
   logic       linha_ativa;
   logic       frame_start;
   logic       tick_linha;

   modport master (
      output enable, auto_alternate, manual_img,
      input  Seletor_Linhas, Seletor_imagem, linha_ativa, frame_start, tick_linha
   );

   modport slave (
      input  enable, auto_alternate, manual_img,
      output Seletor_Linhas, Seletor_imagem, linha_ativa, frame_start, tick_linha
   );
endinterface

// File: rtl/matriz_scan_controller.sv
// LED matrix scan sequencer. A single slot counter splits every row slot into a
// blanking phase followed by a drive phase; rows advance only at slot start
// (while blanked) and the image select changes only when the row wraps to 0.
//   clock - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - control inputs and registered scan outputs (slave modport)
module matriz_scan_controller #(
   parameter int unsigned ROW_PERIOD       = 65536,
   parameter int unsigned BLANK_CYCLES     = 64,
   parameter int unsigned NUM_ROWS         = 8,
   parameter int unsigned FRAMES_PER_IMAGE = 32
) (
   input logic                    clock,
   input logic                    reset,
   matriz_scan_controller_if.slave bus
);

   localparam int unsigned CntW = (ROW_PERIOD > 1) ? $clog2(ROW_PERIOD) : 1;
   localparam int unsigned FrmW = (FRAMES_PER_IMAGE > 1) ? $clog2(FRAMES_PER_IMAGE) : 1;

   localparam logic [CntW-1:0] CntLast  = CntW'(ROW_PERIOD - 1);
   localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);
   localparam logic [2:0]      RowLast  = 3'(NUM_ROWS - 1);
   localparam logic [FrmW-1:0] FrmLast  = FrmW'(FRAMES_PER_IMAGE - 1);

   typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      row_q, row_d;
   logic [FrmW-1:0] frm_q, frm_d;
   logic            img_q, img_d;
   logic            linha_q, linha_d;
   logic            fs_q, fs_d;
   logic            tick_q, tick_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      frm_d   = frm_q;
      img_d   = img_q;
      fs_d    = 1'b0;
      tick_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            row_d = '0;
            frm_d = '0;
            if (bus.enable) begin
               state_d = StBlank;
               fs_d    = 1'b1;
               tick_d  = 1'b1;
            end
         end
         StBlank, StDrive: begin
            if (!bus.enable) begin
               // Image select is deliberately kept so re-enabling shows the same image.
               state_d = StIdle;
               cnt_d   = '0;
               row_d   = '0;
               frm_d   = '0;
            end else if (cnt_q == CntLast) begin
               // Slot boundary: enter blanking before the row select moves.
               state_d = StBlank;
               cnt_d   = '0;
               tick_d  = 1'b1;
               if (row_q == RowLast) begin
                  row_d = '0;
                  fs_d  = 1'b1;
                  if (bus.auto_alternate) begin
                     if (frm_q == FrmLast) begin
                        img_d = ~img_q;
                        frm_d = '0;
                     end else begin
                        frm_d = frm_q + 1'b1;
                     end
                  end else begin
                     img_d = bus.manual_img;
                     frm_d = '0;
                  end
               end else begin
                  row_d = row_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CntBlank) begin
                  state_d = StDrive;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      linha_d = (state_d == StDrive);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         row_q   <= '0;
         frm_q   <= '0;
         img_q   <= 1'b0;
         linha_q <= 1'b0;
         fs_q    <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         frm_q   <= frm_d;
         img_q   <= img_d;
         linha_q <= linha_d;
         fs_q    <= fs_d;
         tick_q  <= tick_d;
      end
   end

   assign bus.Seletor_Linhas = row_q;
   assign bus.Seletor_imagem = img_q;
   assign bus.linha_ativa    = linha_q;
   assign bus.frame_start    = fs_q;
   assign bus.tick_linha     = tick_q;

endmodule

// File: tb/tb_matriz_scan_controller.sv
// Bench for matriz_scan_controller: a time-based reference model (scan position
// derived from edges since enable) checked every cycle, plus directed literal checks.
module tb_matriz_scan_controller;

   localparam int RP  = 8;
   localparam int BL  = 2;
   localparam int NR  = 3;
   localparam int FPI = 2;

   logic clock;
   logic reset;

   matriz_scan_controller_if bus ();

   matriz_scan_controller #(
      .ROW_PERIOD      (RP),
      .BLANK_CYCLES    (BL),
      .NUM_ROWS        (NR),
      .FRAMES_PER_IMAGE(FPI)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_err    = 0;
   int cur_k    = -1;

   // Reference model state: running flag, edges since scan start, frames since
   // last image event, current image.
   int m_run    = 0;
   int m_t      = 0;
   int m_frames = 0;
   int m_img    = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs only change at negedge+#1, so at a negedge they still hold the
   // values sampled at the preceding rising edge.
   initial begin
      int pos, slot, row;
      int e_row, e_linha, e_fs, e_tick;
      forever begin
         @(negedge clock);
         if (!reset) begin
            m_run = 0; m_t = 0; m_frames = 0; m_img = 0;
         end else if (!m_run) begin
            if (bus.enable) begin
               m_run = 1; m_t = 0;
            end
         end else if (!bus.enable) begin
            m_run = 0; m_t = 0; m_frames = 0;
         end else begin
            m_t++;
            if ((m_t % RP == 0) && ((m_t / RP) % NR == 0)) begin
               if (bus.auto_alternate) begin
                  m_frames++;
                  if (m_frames == FPI) begin
                     m_img    = 1 - m_img;
                     m_frames = 0;
                  end
               end else begin
                  m_img    = int'(bus.manual_img);
                  m_frames = 0;
               end
            end
         end

         if (m_run != 0) begin
            pos     = m_t % RP;
            slot    = m_t / RP;
            row     = slot % NR;
            e_row   = row;
            e_linha = (pos >= BL) ? 1 : 0;
            e_tick  = (pos == 0) ? 1 : 0;
            e_fs    = (pos == 0 && row == 0) ? 1 : 0;
         end else begin
            e_row = 0; e_linha = 0; e_tick = 0; e_fs = 0;
         end
         check("model row",   int'(bus.Seletor_Linhas), e_row);
         check("model img",   int'(bus.Seletor_imagem), m_img);
         check("model linha", int'(bus.linha_ativa),    e_linha);
         check("model fs",    int'(bus.frame_start),    e_fs);
         check("model tick",  int'(bus.tick_linha),     e_tick);
      end
   end

   // Advance to the negedge following edge k of the current scan.
   task automatic run_to(input int k);
      while (cur_k < k) begin
         @(negedge clock);
         cur_k++;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " row"},   int'(bus.Seletor_Linhas), 0);
      check({tag, " img"},   int'(bus.Seletor_imagem), 0);
      check({tag, " linha"}, int'(bus.linha_ativa),    0);
      check({tag, " fs"},    int'(bus.frame_start),    0);
      check({tag, " tick"},  int'(bus.tick_linha),     0);
   endtask

   initial begin
      int rst_hold;
      reset              = 1'b1;
      bus.enable         = 1'b1;
      bus.auto_alternate = 1'(($urandom_range(1)));
      bus.manual_img     = 1'b1;
      #1 reset = 1'b0;
      #1 check_zero("async reset");
      repeat (3) @(negedge clock);
      check_zero("held reset");
      #1;
      reset      = 1'b1;
      bus.enable = 1'b0;
      repeat (3) @(negedge clock);
      check_zero("idle after reset");

      // Row scan and auto image.
      #1;
      bus.auto_alternate = 1'b1;
      bus.enable         = 1'b1;
      cur_k              = -1;
      run_to(0);
      check("e0 fs", int'(bus.frame_start), 1);
      check("e0 tick", int'(bus.tick_linha), 1);
      check("e0 linha", int'(bus.linha_ativa), 0);
      run_to(1);  check("e1 linha", int'(bus.linha_ativa), 0);
      run_to(2);  check("e2 linha", int'(bus.linha_ativa), 1);
      run_to(7);  check("e7 linha", int'(bus.linha_ativa), 1);
      run_to(8);
      check("e8 row", int'(bus.Seletor_Linhas), 1);
      check("e8 linha", int'(bus.linha_ativa), 0);
      check("e8 tick", int'(bus.tick_linha), 1);
      check("e8 fs", int'(bus.frame_start), 0);
      run_to(16); check("e16 row", int'(bus.Seletor_Linhas), 2);
      run_to(24);
      check("e24 row", int'(bus.Seletor_Linhas), 0);
      check("e24 fs", int'(bus.frame_start), 1);
      check("e24 img", int'(bus.Seletor_imagem), 0);
      run_to(47); check("e47 img", int'(bus.Seletor_imagem), 0);
      run_to(48); check("e48 img", int'(bus.Seletor_imagem), 1);

      // Disable mid-row (sampled at edge 61), image retained, then restart.
      run_to(60);
      #1 bus.enable = 1'b0;
      run_to(61);
      check("dis linha", int'(bus.linha_ativa), 0);
      check("dis row", int'(bus.Seletor_Linhas), 0);
      check("dis img", int'(bus.Seletor_imagem), 1);
      #1 bus.enable = 1'b1;
      cur_k = -1;
      run_to(0);
      check("re fs", int'(bus.frame_start), 1);
      check("re row", int'(bus.Seletor_Linhas), 0);
      check("re img", int'(bus.Seletor_imagem), 1);
      run_to(24); check("re e24 img", int'(bus.Seletor_imagem), 1);
      run_to(48); check("re e48 img", int'(bus.Seletor_imagem), 0);

      // Manual image.
      #1 bus.enable = 1'b0;
      @(negedge clock);
      #1;
      bus.auto_alternate = 1'b0;
      bus.manual_img     = 1'b0;
      bus.enable         = 1'b1;
      cur_k              = -1;
      run_to(4);  #1 bus.manual_img = 1'b1;
      run_to(23); check("man e23 img", int'(bus.Seletor_imagem), 0);
      run_to(24); check("man e24 img", int'(bus.Seletor_imagem), 1);
      run_to(29); #1 bus.manual_img = 1'b0;
      run_to(34); #1 bus.manual_img = 1'b1;
      run_to(39); #1 bus.manual_img = 1'b0;
      run_to(47); check("man e47 img", int'(bus.Seletor_imagem), 1);
      run_to(48); check("man e48 img", int'(bus.Seletor_imagem), 0);
      #1 bus.manual_img = 1'b1;
      run_to(72); check("man e72 img", int'(bus.Seletor_imagem), 1);

      // Async reset in the drive phase of a slot.
      run_to(91);
      check("pre-rst linha", int'(bus.linha_ativa), 1);
      #2 reset = 1'b0;
      #1 check_zero("mid-drive reset");
      @(negedge clock);
      #1 reset = 1'b1;
      cur_k = -1;
      run_to(0);
      check("post-rst fs", int'(bus.frame_start), 1);
      check("post-rst row", int'(bus.Seletor_Linhas), 0);
      check("post-rst img", int'(bus.Seletor_imagem), 0);

      // Randomized traffic against the model.
      rst_hold = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         #1;
         if ($urandom_range(199) == 0) bus.enable = ~bus.enable;
         if ($urandom_range(99) == 0) bus.auto_alternate = ~bus.auto_alternate;
         if ($urandom_range(9) == 0) bus.manual_img = 1'($urandom_range(1));
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) reset = 1'b1;
         end else if ($urandom_range(999) == 0) begin
            reset    = 1'b0;
            rst_hold = 2;
         end
      end
      reset = 1'b1;
      repeat (2) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
